// File: rtl/core_sequencer.sv
// Run-control and fetch sequencer for the 8-bit accumulator core.
// Optional breakpoint compare is built when SEQ_BREAKPOINT_EN is defined.
module core_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int TO_CYC  = 15,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [PC_W-1:0]    PC,
  input  logic               RUN,
  input  logic               STEP,
  input  logic               HALT,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic               CORE_EN,
  output logic               HALTED,
  output logic               FAULT,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [PC_W-1:0]    BP_ADDR,
  output logic               BP_HIT,
`endif
  output logic [CNT_W-1:0]   RETIRED
);

  // state    | meaning
  // ST_IDLE  | halted, waiting for RUN or STEP
  // ST_FETCH | REQ high until ACK or timeout
  // ST_EXEC  | one-cycle core enable, instruction retires
  // ST_ERROR | fetch timed out, sticky until reset
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_ERROR} state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [7:0]         to_cnt_q, to_cnt_d;
  logic [7:0]         to_cnt_inc;
  logic               step_only_q, step_only_d;
  logic               halt_pend_q, halt_pend_d;
`ifdef SEQ_BREAKPOINT_EN
  logic               bp_hit_q, bp_hit_d;
  logic               bp_chk_q, bp_chk_d;
`endif

  assign to_cnt_inc = to_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    retired_d   = retired_q;
    to_cnt_d    = to_cnt_q;
    step_only_d = step_only_q;
    halt_pend_d = halt_pend_q;
`ifdef SEQ_BREAKPOINT_EN
    bp_hit_d    = bp_hit_q;
    bp_chk_d    = bp_chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        halt_pend_d = 1'b0;
        if (RUN || STEP) begin
          state_d     = ST_FETCH;
          step_only_d = !RUN;
          to_cnt_d    = 8'd0;
`ifdef SEQ_BREAKPOINT_EN
          bp_hit_d    = 1'b0;
          bp_chk_d    = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (HALT) halt_pend_d = 1'b1;
`ifdef SEQ_BREAKPOINT_EN
        // The PC after an EXEC is only valid now, so the first free-run
        // FETCH cycle is spent on the compare with REQ held low.
        if (bp_chk_q) begin
          bp_chk_d = 1'b0;
          if (PC == BP_ADDR) begin
            state_d     = ST_IDLE;
            bp_hit_d    = 1'b1;
            halt_pend_d = 1'b0;
          end
        end else
`endif
        if (IMEM_ACK) begin
          instr_d = IMEM_RDATA;
          state_d = ST_EXEC;
        end else if (to_cnt_inc == TO_LIM) begin
          state_d = ST_ERROR;
          fault_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + CNT_W'(1);
        if (step_only_q || halt_pend_q || HALT || !RUN) begin
          state_d     = ST_IDLE;
          halt_pend_d = 1'b0;
        end else begin
          state_d  = ST_FETCH;
          to_cnt_d = 8'd0;
`ifdef SEQ_BREAKPOINT_EN
          bp_chk_d = 1'b1;
`endif
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      fault_q     <= 1'b0;
      retired_q   <= '0;
      to_cnt_q    <= 8'd0;
      step_only_q <= 1'b0;
      halt_pend_q <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      bp_hit_q    <= 1'b0;
      bp_chk_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      fault_q     <= fault_d;
      retired_q   <= retired_d;
      to_cnt_q    <= to_cnt_d;
      step_only_q <= step_only_d;
      halt_pend_q <= halt_pend_d;
`ifdef SEQ_BREAKPOINT_EN
      bp_hit_q    <= bp_hit_d;
      bp_chk_q    <= bp_chk_d;
`endif
    end
  end

  assign IMEM_ADDR = PC;
`ifdef SEQ_BREAKPOINT_EN
  assign IMEM_REQ  = (state_q == ST_FETCH) && !bp_chk_q;
  assign BP_HIT    = bp_hit_q;
`else
  assign IMEM_REQ  = (state_q == ST_FETCH);
`endif
  assign CORE_EN   = (state_q == ST_EXEC);
  assign HALTED    = (state_q == ST_IDLE) || (state_q == ST_ERROR);
  assign INSTR     = instr_q;
  assign FAULT     = fault_q;
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with an instruction scoreboard checked
// on every CORE_EN pulse, plus a memory responder and a PC-increment model.
module tb_core_sequencer;

  logic        clk_sys;
  logic        rstn;
  logic [7:0]  pc;
  logic        run, step, halt;
  logic [7:0]  imem_addr;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_rdata;
  logic [7:0]  instr;
  logic        core_en, halted, fault;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_count = 0;
  int wait_cyc = 0;
  int req_cnt  = 0;
  bit no_ack   = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_q [$];

  core_sequencer #(.PC_W(8), .INSTR_W(8), .TO_CYC(15), .CNT_W(16)) dut (
    .CLK(clk_sys), .RSTN(rstn), .PC(pc), .RUN(run), .STEP(step), .HALT(halt),
    .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req), .IMEM_ACK(imem_ack),
    .IMEM_RDATA(imem_rdata), .INSTR(instr), .CORE_EN(core_en),
    .HALTED(halted), .FAULT(fault), .RETIRED(retired)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  // memory responder: ACK after wait_cyc REQ cycles
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (imem_req === 1'b1) begin
        if (!no_ack && req_cnt >= wait_cyc) begin
          imem_ack = 1'b1;
          imem_rdata = mem[imem_addr[3:0]];
        end else begin
          imem_ack = 1'b0;
        end
        req_cnt++;
      end else begin
        imem_ack = 1'b0;
        req_cnt = 0;
      end
    end
  end

  // core model: PC advances on each enabled core cycle
  initial begin
    pc = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (core_en === 1'b1) pc = pc + 8'd1;
    end
  end

  // scoreboard monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_sys);
      if (core_en === 1'b1) begin
        ce_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL instr_exec: unexpected CORE_EN, INSTR=%0h, no instruction expected", instr);
        end else begin
          e = exp_q.pop_front();
          check("instr_exec", {24'h0, instr}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[0] = 8'h3C; mem[1] = 8'h41; mem[2] = 8'h7F; mem[3] = 8'hA5;
    mem[4] = 8'h5A; mem[5] = 8'h11; mem[6] = 8'h22; mem[7] = 8'h33;
    mem[8] = 8'h44;
    for (int i = 9; i < 16; i++) mem[i] = 8'hEE;
    rstn = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0;

    // reset state
    tick(); tick();
    check("rst_halted", halted, 1);
    check("rst_core_en", core_en, 0);
    check("rst_req", imem_req, 0);
    check("rst_fault", fault, 0);
    check("rst_retired", retired, 0);
    check("rst_instr", instr, 0);
    rstn = 1'b1;
    tick();

    // zero-wait run of three instructions
    begin
      logic [5:0] ce_pat;
      ce_pat = 6'b101010;
      tick(); run = 1'b1;
      exp_q.push_back(8'h3C); exp_q.push_back(8'h41); exp_q.push_back(8'h7F);
      for (int i = 1; i <= 6; i++) begin
        tick();
        if (i == 5) run = 1'b0;
        check("zw_core_en", core_en, ce_pat[i-1]);
      end
      tick();
      check("zw_halted", halted, 1);
      check("zw_retired", retired, 3);
    end

    // three wait states
    wait_cyc = 3;
    tick(); run = 1'b1;
    exp_q.push_back(8'hA5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) run = 1'b0;
      check("ws_req", imem_req, (i <= 4));
      check("ws_core_en", core_en, (i == 5));
      if (i <= 4) check("ws_instr_hold", instr, 8'h7F);
    end
    tick();
    check("ws_halted", halted, 1);
    check("ws_fault", fault, 0);
    check("ws_retired", retired, 4);

    // single step
    wait_cyc = 0;
    tick(); step = 1'b1;
    exp_q.push_back(8'h5A);
    tick(); step = 1'b0;
    check("st_req", imem_req, 1);
    check("st_running", halted, 0);
    tick();
    check("st_core_en", core_en, 1);
    tick();
    check("st_halted", halted, 1);
    begin
      int ce_before;
      ce_before = ce_count;
      repeat (3) tick();
      check("st_one_pulse", ce_count - ce_before, 0);
    end
    check("st_retired", retired, 5);

    // STEP and RUN together free-run
    tick(); run = 1'b1; step = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    tick(); step = 1'b0;
    tick();
    check("sr_core_en1", core_en, 1);
    tick();
    check("sr_refetch", imem_req, 1);
    check("sr_running", halted, 0);
    run = 1'b0;
    tick();
    check("sr_core_en2", core_en, 1);
    tick();
    check("sr_halted", halted, 1);
    check("sr_retired", retired, 7);

    // HALT in second wait cycle, RUN held
    wait_cyc = 3;
    tick(); run = 1'b1;
    exp_q.push_back(8'h33);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 2) halt = 1'b1;
      if (i == 3) halt = 1'b0;
      if (i <= 5) check("hl_core_en", core_en, (i == 5));
      if (i == 6) begin
        check("hl_halted", halted, 1);
        run = 1'b0;
      end
    end
    repeat (3) begin
      tick();
      check("hl_no_req", imem_req, 0);
    end
    check("hl_retired", retired, 8);

    // ACK on the same cycle the timeout would fire
    wait_cyc = 14;
    tick(); run = 1'b1;
    exp_q.push_back(8'h44);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) run = 1'b0;
      if (i == 15) check("aw_req", imem_req, 1);
      if (i == 16) check("aw_core_en", core_en, 1);
    end
    tick();
    check("aw_fault", fault, 0);
    check("aw_halted", halted, 1);
    check("aw_retired", retired, 9);

    // fetch timeout
    no_ack = 1;
    tick(); run = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("to_req", imem_req, 1);
      check("to_fault_pre", fault, 0);
    end
    tick();
    check("to_req_drop", imem_req, 0);
    check("to_fault", fault, 1);
    check("to_halted", halted, 1);
    repeat (3) begin
      tick();
      check("to_stuck_req", imem_req, 0);
      check("to_stuck_fault", fault, 1);
    end
    rstn = 1'b0; run = 1'b0;
    tick();
    rstn = 1'b1;
    check("to_rst_fault", fault, 0);
    check("to_rst_halted", halted, 1);
    check("to_rst_retired", retired, 0);
    check("to_rst_instr", instr, 0);
    no_ack = 0;
    tick();
    check("to_rst_idle", halted, 1);

    check("sb_drained", exp_q.size(), 0);
    check("ce_total", ce_count, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
